// File: rtl/mem_stage.sv
// Memory pipeline stage: issues word-aligned data-bus requests for loads and stores and registers writeback.
// Optional build macro MEM_MISALIGN_EXC_EN turns misaligned half/word accesses into exceptions (code 4 load, 6 store).
module mem_stage (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FLUSH,
    input  logic        IN_VALID,
    input  logic        IN_REG_W_EN,
    input  logic [4:0]  IN_REG_W_RD,
    input  logic [31:0] IN_REG_W_DATA,
    input  logic        IN_MEM_R_EN,
    input  logic [4:0]  IN_MEM_R_RD,
    input  logic [31:0] IN_MEM_R_ADDR,
    input  logic [3:0]  IN_MEM_R_STRB,
    input  logic        IN_MEM_R_SIGNED,
    input  logic        IN_MEM_W_EN,
    input  logic [31:0] IN_MEM_W_ADDR,
    input  logic [3:0]  IN_MEM_W_STRB,
    input  logic [31:0] IN_MEM_W_DATA,
    input  logic        IN_EXC_EN,
    input  logic [3:0]  IN_EXC_CODE,
    output logic        MEM_WAIT,
    output logic        DMEM_REQ_VALID,
    input  logic        DMEM_REQ_READY,
    output logic        DMEM_REQ_WE,
    output logic [31:0] DMEM_REQ_ADDR,
    output logic [3:0]  DMEM_REQ_STRB,
    output logic [31:0] DMEM_REQ_WDATA,
    input  logic        DMEM_RESP_VALID,
    input  logic [31:0] DMEM_RESP_RDATA,
    output logic        WB_VALID,
    output logic        WB_REG_W_EN,
    output logic [4:0]  WB_REG_W_RD,
    output logic [31:0] WB_REG_W_DATA,
    output logic        WB_EXC_EN,
    output logic [3:0]  WB_EXC_CODE
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DRAIN} state_t;

    state_t state, state_nx;

    // Operation latched at acceptance; bus fields are pre-aligned so they stay stable through REQ.
    logic        lat_we;
    logic        lat_signed;
    logic        lat_half;
    logic        lat_word;
    logic [1:0]  lat_off;
    logic [4:0]  lat_rd;
    logic [31:0] req_addr_q;
    logic [3:0]  req_strb_q;
    logic [31:0] req_wdata_q;

    logic        mem_op;
    logic [31:0] op_addr;
    logic [3:0]  op_strb;
    logic [3:0]  op_strb_sh;
    logic [1:0]  op_off;
    logic        misaligned;
    logic        accept;

    logic [31:0] rdata_sh;
    logic [31:0] load_data;

    logic        wb_valid_nx;
    logic        wb_en_nx;
    logic [4:0]  wb_rd_nx;
    logic [31:0] wb_data_nx;
    logic        wb_exc_nx;
    logic [3:0]  wb_code_nx;

    // A read takes precedence when both request flags are set.
    assign mem_op  = IN_MEM_R_EN | IN_MEM_W_EN;
    assign op_addr = IN_MEM_R_EN ? IN_MEM_R_ADDR : IN_MEM_W_ADDR;
    assign op_strb = IN_MEM_R_EN ? IN_MEM_R_STRB : IN_MEM_W_STRB;
    assign op_off  = op_addr[1:0];

    always_comb begin
        case (op_off)
            2'd0:    op_strb_sh = op_strb;
            2'd1:    op_strb_sh = {op_strb[2:0], 1'b0};
            2'd2:    op_strb_sh = {op_strb[1:0], 2'b00};
            default: op_strb_sh = {op_strb[0], 3'b000};
        endcase
    end

`ifdef MEM_MISALIGN_EXC_EN
    assign misaligned = (op_strb[3] && (op_off != 2'b00)) ||
                        (!op_strb[3] && op_strb[1] && op_off[0]);
`else
    assign misaligned = 1'b0;
`endif

    assign accept = (state == IDLE) && !FLUSH && IN_VALID && !IN_EXC_EN && mem_op && !misaligned;

    assign rdata_sh = DMEM_RESP_RDATA >> {lat_off, 3'b000};

    always_comb begin
        if (lat_word)
            load_data = rdata_sh;
        else if (lat_half)
            load_data = {{16{lat_signed & rdata_sh[15]}}, rdata_sh[15:0]};
        else
            load_data = {{24{lat_signed & rdata_sh[7]}}, rdata_sh[7:0]};
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_nx = state;
        case (state)
            IDLE:  if (accept) state_nx = REQ;
            REQ: begin
                if (FLUSH)
                    state_nx = (DMEM_REQ_READY && !lat_we) ? DRAIN : IDLE;
                else if (DMEM_REQ_READY)
                    state_nx = lat_we ? IDLE : RESP;
            end
            // A response coinciding with a flush is simply dropped; DRAIN would otherwise wait forever.
            RESP: begin
                if (DMEM_RESP_VALID)
                    state_nx = IDLE;
                else if (FLUSH)
                    state_nx = DRAIN;
            end
            DRAIN: if (DMEM_RESP_VALID) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        wb_valid_nx = 1'b0;
        wb_en_nx    = 1'b0;
        wb_rd_nx    = 5'd0;
        wb_data_nx  = 32'd0;
        wb_exc_nx   = 1'b0;
        wb_code_nx  = 4'd0;
        if (!FLUSH) begin
            case (state)
                IDLE: begin
                    if (IN_VALID && (IN_EXC_EN || !mem_op)) begin
                        wb_valid_nx = 1'b1;
                        wb_en_nx    = IN_REG_W_EN;
                        wb_rd_nx    = IN_REG_W_RD;
                        wb_data_nx  = IN_REG_W_DATA;
                        wb_exc_nx   = IN_EXC_EN;
                        wb_code_nx  = IN_EXC_CODE;
                    end else if (IN_VALID && misaligned) begin
                        wb_valid_nx = 1'b1;
                        wb_exc_nx   = 1'b1;
                        wb_code_nx  = IN_MEM_R_EN ? 4'd4 : 4'd6;
                    end
                end
                REQ: begin
                    if (DMEM_REQ_READY && lat_we)
                        wb_valid_nx = 1'b1;
                end
                RESP: begin
                    if (DMEM_RESP_VALID) begin
                        wb_valid_nx = 1'b1;
                        wb_en_nx    = 1'b1;
                        wb_rd_nx    = lat_rd;
                        wb_data_nx  = load_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (RST) begin
            state         <= IDLE;
            WB_VALID      <= 1'b0;
            WB_REG_W_EN   <= 1'b0;
            WB_REG_W_RD   <= 5'd0;
            WB_REG_W_DATA <= 32'd0;
            WB_EXC_EN     <= 1'b0;
            WB_EXC_CODE   <= 4'd0;
            lat_we        <= 1'b0;
            lat_signed    <= 1'b0;
            lat_half      <= 1'b0;
            lat_word      <= 1'b0;
            lat_off       <= 2'd0;
            lat_rd        <= 5'd0;
            req_addr_q    <= 32'd0;
            req_strb_q    <= 4'd0;
            req_wdata_q   <= 32'd0;
        end else begin
            state         <= state_nx;
            WB_VALID      <= wb_valid_nx;
            WB_REG_W_EN   <= wb_en_nx;
            WB_REG_W_RD   <= wb_rd_nx;
            WB_REG_W_DATA <= wb_data_nx;
            WB_EXC_EN     <= wb_exc_nx;
            WB_EXC_CODE   <= wb_code_nx;
            if (accept) begin
                lat_we      <= !IN_MEM_R_EN;
                lat_signed  <= IN_MEM_R_SIGNED;
                lat_word    <= op_strb[3];
                lat_half    <= !op_strb[3] && op_strb[1];
                lat_off     <= op_off;
                lat_rd      <= IN_MEM_R_RD;
                req_addr_q  <= {op_addr[31:2], 2'b00};
                req_strb_q  <= op_strb_sh;
                req_wdata_q <= IN_MEM_R_EN ? 32'd0 : (IN_MEM_W_DATA << {op_off, 3'b000});
            end
        end
    end

    assign MEM_WAIT       = (state != IDLE);
    assign DMEM_REQ_VALID = (state == REQ);
    assign DMEM_REQ_WE    = (state == REQ) && lat_we;
    assign DMEM_REQ_ADDR  = (state == REQ) ? req_addr_q  : 32'd0;
    assign DMEM_REQ_STRB  = (state == REQ) ? req_strb_q  : 4'd0;
    assign DMEM_REQ_WDATA = (state == REQ) ? req_wdata_q : 32'd0;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected bus requests and writebacks into queues,
// and a negedge monitor pops and compares them whenever the DUT presents one.
module tb_mem_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        FLUSH;
    logic        IN_VALID;
    logic        IN_REG_W_EN;
    logic [4:0]  IN_REG_W_RD;
    logic [31:0] IN_REG_W_DATA;
    logic        IN_MEM_R_EN;
    logic [4:0]  IN_MEM_R_RD;
    logic [31:0] IN_MEM_R_ADDR;
    logic [3:0]  IN_MEM_R_STRB;
    logic        IN_MEM_R_SIGNED;
    logic        IN_MEM_W_EN;
    logic [31:0] IN_MEM_W_ADDR;
    logic [3:0]  IN_MEM_W_STRB;
    logic [31:0] IN_MEM_W_DATA;
    logic        IN_EXC_EN;
    logic [3:0]  IN_EXC_CODE;
    logic        MEM_WAIT;
    logic        DMEM_REQ_VALID;
    logic        DMEM_REQ_READY;
    logic        DMEM_REQ_WE;
    logic [31:0] DMEM_REQ_ADDR;
    logic [3:0]  DMEM_REQ_STRB;
    logic [31:0] DMEM_REQ_WDATA;
    logic        DMEM_RESP_VALID;
    logic [31:0] DMEM_RESP_RDATA;
    logic        WB_VALID;
    logic        WB_REG_W_EN;
    logic [4:0]  WB_REG_W_RD;
    logic [31:0] WB_REG_W_DATA;
    logic        WB_EXC_EN;
    logic [3:0]  WB_EXC_CODE;

    typedef struct packed {
        logic        en;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exc;
        logic [3:0]  code;
    } wb_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } bus_t;

    wb_t  wb_q[$];
    bus_t bus_q[$];
    wb_t  wb_e;
    bus_t bus_e;

    int checks = 0;
    int errors = 0;
    int wait_total = 0;
    int w0;
    bit mon_en = 1'b0;

    always #5 CLK = ~CLK;

    mem_stage dut (
        .CLK             (CLK),
        .RST             (RST),
        .FLUSH           (FLUSH),
        .IN_VALID        (IN_VALID),
        .IN_REG_W_EN     (IN_REG_W_EN),
        .IN_REG_W_RD     (IN_REG_W_RD),
        .IN_REG_W_DATA   (IN_REG_W_DATA),
        .IN_MEM_R_EN     (IN_MEM_R_EN),
        .IN_MEM_R_RD     (IN_MEM_R_RD),
        .IN_MEM_R_ADDR   (IN_MEM_R_ADDR),
        .IN_MEM_R_STRB   (IN_MEM_R_STRB),
        .IN_MEM_R_SIGNED (IN_MEM_R_SIGNED),
        .IN_MEM_W_EN     (IN_MEM_W_EN),
        .IN_MEM_W_ADDR   (IN_MEM_W_ADDR),
        .IN_MEM_W_STRB   (IN_MEM_W_STRB),
        .IN_MEM_W_DATA   (IN_MEM_W_DATA),
        .IN_EXC_EN       (IN_EXC_EN),
        .IN_EXC_CODE     (IN_EXC_CODE),
        .MEM_WAIT        (MEM_WAIT),
        .DMEM_REQ_VALID  (DMEM_REQ_VALID),
        .DMEM_REQ_READY  (DMEM_REQ_READY),
        .DMEM_REQ_WE     (DMEM_REQ_WE),
        .DMEM_REQ_ADDR   (DMEM_REQ_ADDR),
        .DMEM_REQ_STRB   (DMEM_REQ_STRB),
        .DMEM_REQ_WDATA  (DMEM_REQ_WDATA),
        .DMEM_RESP_VALID (DMEM_RESP_VALID),
        .DMEM_RESP_RDATA (DMEM_RESP_RDATA),
        .WB_VALID        (WB_VALID),
        .WB_REG_W_EN     (WB_REG_W_EN),
        .WB_REG_W_RD     (WB_REG_W_RD),
        .WB_REG_W_DATA   (WB_REG_W_DATA),
        .WB_EXC_EN       (WB_EXC_EN),
        .WB_EXC_CODE     (WB_EXC_CODE)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_in();
        FLUSH           = 1'b0;
        IN_VALID        = 1'b0;
        IN_REG_W_EN     = 1'b0;
        IN_REG_W_RD     = 5'd0;
        IN_REG_W_DATA   = 32'd0;
        IN_MEM_R_EN     = 1'b0;
        IN_MEM_R_RD     = 5'd0;
        IN_MEM_R_ADDR   = 32'd0;
        IN_MEM_R_STRB   = 4'd0;
        IN_MEM_R_SIGNED = 1'b0;
        IN_MEM_W_EN     = 1'b0;
        IN_MEM_W_ADDR   = 32'd0;
        IN_MEM_W_STRB   = 4'd0;
        IN_MEM_W_DATA   = 32'd0;
        IN_EXC_EN       = 1'b0;
        IN_EXC_CODE     = 4'd0;
        DMEM_REQ_READY  = 1'b0;
        DMEM_RESP_VALID = 1'b0;
        DMEM_RESP_RDATA = 32'd0;
    endtask

    task automatic push_wb(input logic en, input logic [4:0] rd, input logic [31:0] data,
                           input logic exc, input logic [3:0] code);
        wb_t w;
        w.en = en; w.rd = rd; w.data = data; w.exc = exc; w.code = code;
        wb_q.push_back(w);
    endtask

    task automatic push_bus(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                            input logic [31:0] wdata);
        bus_t b;
        b.we = we; b.addr = addr; b.strb = strb; b.wdata = wdata;
        bus_q.push_back(b);
    endtask

    task automatic issue_load(input logic [4:0] rd, input logic [31:0] addr, input logic [3:0] strb,
                              input logic sgn);
        IN_VALID        = 1'b1;
        IN_MEM_R_EN     = 1'b1;
        IN_MEM_R_RD     = rd;
        IN_MEM_R_ADDR   = addr;
        IN_MEM_R_STRB   = strb;
        IN_MEM_R_SIGNED = sgn;
    endtask

    task automatic issue_store(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data);
        IN_VALID      = 1'b1;
        IN_MEM_W_EN   = 1'b1;
        IN_MEM_W_ADDR = addr;
        IN_MEM_W_STRB = strb;
        IN_MEM_W_DATA = data;
    endtask

    // Load with immediate READY and the response after `lat` extra RESP cycles.
    task automatic run_load(input logic [4:0] rd, input logic [31:0] addr, input logic [3:0] strb,
                            input logic sgn, input logic [31:0] rdata, input int lat);
        issue_load(rd, addr, strb, sgn);
        step();
        idle_in();
        DMEM_REQ_READY = 1'b1;
        step();
        DMEM_REQ_READY = 1'b0;
        repeat (lat) step();
        DMEM_RESP_VALID = 1'b1;
        DMEM_RESP_RDATA = rdata;
        step();
        DMEM_RESP_VALID = 1'b0;
        DMEM_RESP_RDATA = 32'd0;
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            if (MEM_WAIT) wait_total++;
            if (WB_VALID) begin
                if (wb_q.size() == 0) begin
                    check("wb_unexpected", 32'd1, 32'd0);
                end else begin
                    wb_e = wb_q.pop_front();
                    check("wb_reg_w_en", {31'd0, WB_REG_W_EN}, {31'd0, wb_e.en});
                    check("wb_reg_w_rd", {27'd0, WB_REG_W_RD}, {27'd0, wb_e.rd});
                    check("wb_reg_w_data", WB_REG_W_DATA, wb_e.data);
                    check("wb_exc_en", {31'd0, WB_EXC_EN}, {31'd0, wb_e.exc});
                    check("wb_exc_code", {28'd0, WB_EXC_CODE}, {28'd0, wb_e.code});
                end
            end else begin
                check("wb_idle_zero",
                      {31'd0, |{WB_REG_W_EN, WB_REG_W_RD, WB_REG_W_DATA, WB_EXC_EN, WB_EXC_CODE}}, 32'd0);
            end
            if (DMEM_REQ_VALID && DMEM_REQ_READY) begin
                if (bus_q.size() == 0) begin
                    check("bus_unexpected", 32'd1, 32'd0);
                end else begin
                    bus_e = bus_q.pop_front();
                    check("bus_we", {31'd0, DMEM_REQ_WE}, {31'd0, bus_e.we});
                    check("bus_addr", DMEM_REQ_ADDR, bus_e.addr);
                    check("bus_strb", {28'd0, DMEM_REQ_STRB}, {28'd0, bus_e.strb});
                    check("bus_wdata", DMEM_REQ_WDATA, bus_e.wdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        idle_in();
        step();
        step();
        RST = 1'b0;
        check("rst_mem_wait", {31'd0, MEM_WAIT}, 32'd0);
        check("rst_req_valid", {31'd0, DMEM_REQ_VALID}, 32'd0);
        check("rst_req_addr", DMEM_REQ_ADDR, 32'd0);
        check("rst_wb_valid", {31'd0, WB_VALID}, 32'd0);
        mon_en = 1'b1;

        // ALU write x5=7, then an upstream exception carrying a load that must not reach the bus
        IN_VALID = 1'b1; IN_REG_W_EN = 1'b1; IN_REG_W_RD = 5'd5; IN_REG_W_DATA = 32'd7;
        push_wb(1'b1, 5'd5, 32'd7, 1'b0, 4'd0);
        step();
        check("alu_mem_wait_d0", {31'd0, MEM_WAIT}, 32'd0);
        check("alu_wb_valid", {31'd0, WB_VALID}, 32'd1);
        check("alu_wb_data", WB_REG_W_DATA, 32'd7);
        idle_in();
        IN_VALID = 1'b1; IN_EXC_EN = 1'b1; IN_EXC_CODE = 4'd2;
        IN_MEM_R_EN = 1'b1; IN_MEM_R_ADDR = 32'h100; IN_MEM_R_STRB = 4'b1111;
        push_wb(1'b0, 5'd0, 32'd0, 1'b1, 4'd2);
        step();
        idle_in();
        check("exc_mem_wait", {31'd0, MEM_WAIT}, 32'd0);
        check("exc_req_valid", {31'd0, DMEM_REQ_VALID}, 32'd0);
        step();
        check("alu_wb_drop", {31'd0, WB_VALID}, 32'd0);

        // LB signed at 0x103: READY on 2nd REQ cycle, response 3 cycles after READY
        issue_load(5'd3, 32'h103, 4'b0001, 1'b1);
        push_bus(1'b0, 32'h100, 4'b1000, 32'd0);
        push_wb(1'b1, 5'd3, 32'hFFFF_FF80, 1'b0, 4'd0);
        step();
        idle_in();
        w0 = wait_total;
        check("lb_req_valid", {31'd0, DMEM_REQ_VALID}, 32'd1);
        check("lb_req_addr", DMEM_REQ_ADDR, 32'h100);
        step();
        DMEM_REQ_READY = 1'b1;
        step();
        DMEM_REQ_READY = 1'b0;
        step();
        step();
        DMEM_RESP_VALID = 1'b1; DMEM_RESP_RDATA = 32'h80AA_BBCC;
        step();
        DMEM_RESP_VALID = 1'b0; DMEM_RESP_RDATA = 32'd0;
        check("lb_wb_data", WB_REG_W_DATA, 32'hFFFF_FF80);
        check("lb_mem_wait_low", {31'd0, MEM_WAIT}, 32'd0);
        step();
        check("lb_mem_wait_cycles", wait_total - w0, 32'd5);

        // SH 0x1234 at 0x202 with READY delayed 2 cycles; fields must hold
        issue_store(32'h202, 4'b0011, 32'h1234);
        push_bus(1'b1, 32'h200, 4'b1100, 32'h1234_0000);
        push_wb(1'b0, 5'd0, 32'd0, 1'b0, 4'd0);
        step();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            check("sh_req_valid", {31'd0, DMEM_REQ_VALID}, 32'd1);
            check("sh_req_addr", DMEM_REQ_ADDR, 32'h200);
            check("sh_req_strb", {28'd0, DMEM_REQ_STRB}, 32'hC);
            check("sh_req_wdata", DMEM_REQ_WDATA, 32'h1234_0000);
            if (i == 2) DMEM_REQ_READY = 1'b1;
            step();
        end
        DMEM_REQ_READY = 1'b0;
        check("sh_wb_valid", {31'd0, WB_VALID}, 32'd1);
        check("sh_wb_reg_w_en", {31'd0, WB_REG_W_EN}, 32'd0);
        check("sh_mem_wait", {31'd0, MEM_WAIT}, 32'd0);

        // Extension variants
        push_bus(1'b0, 32'h0, 4'b1100, 32'd0);
        push_wb(1'b1, 5'd4, 32'h0000_8001, 1'b0, 4'd0);
        run_load(5'd4, 32'h2, 4'b0011, 1'b0, 32'h8001_0000, 0);
        push_bus(1'b0, 32'h4, 4'b1100, 32'd0);
        push_wb(1'b1, 5'd6, 32'hFFFF_8001, 1'b0, 4'd0);
        run_load(5'd6, 32'h6, 4'b0011, 1'b1, 32'h8001_0000, 1);
        push_bus(1'b0, 32'h100, 4'b0010, 32'd0);
        push_wb(1'b1, 5'd10, 32'h0000_00F0, 1'b0, 4'd0);
        run_load(5'd10, 32'h101, 4'b0001, 1'b0, 32'h0000_F000, 2);
        push_bus(1'b0, 32'h8, 4'b1111, 32'd0);
        push_wb(1'b1, 5'd11, 32'h1234_5678, 1'b0, 4'd0);
        run_load(5'd11, 32'h8, 4'b1111, 1'b1, 32'h1234_5678, 0);

        // FLUSH in RESP of LW: drain 0xDEADBEEF, no writeback
        issue_load(5'd7, 32'h40, 4'b1111, 1'b0);
        push_bus(1'b0, 32'h40, 4'b1111, 32'd0);
        step();
        idle_in();
        DMEM_REQ_READY = 1'b1;
        step();
        DMEM_REQ_READY = 1'b0;
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        check("drain_mem_wait_0", {31'd0, MEM_WAIT}, 32'd1);
        step();
        check("drain_mem_wait_1", {31'd0, MEM_WAIT}, 32'd1);
        DMEM_RESP_VALID = 1'b1; DMEM_RESP_RDATA = 32'hDEAD_BEEF;
        step();
        idle_in();
        check("drain_mem_wait_end", {31'd0, MEM_WAIT}, 32'd0);
        check("drain_wb_valid", {31'd0, WB_VALID}, 32'd0);

        // FLUSH with READY on a store: commits, no writeback
        issue_store(32'h13, 4'b0001, 32'hAB);
        push_bus(1'b1, 32'h10, 4'b1000, 32'hAB00_0000);
        step();
        idle_in();
        DMEM_REQ_READY = 1'b1; FLUSH = 1'b1;
        step();
        idle_in();
        check("fst_mem_wait", {31'd0, MEM_WAIT}, 32'd0);
        check("fst_wb_valid", {31'd0, WB_VALID}, 32'd0);

        // FLUSH in REQ without READY: request dropped
        issue_load(5'd12, 32'h20, 4'b1111, 1'b0);
        step();
        idle_in();
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        check("fld_mem_wait", {31'd0, MEM_WAIT}, 32'd0);
        check("fld_req_valid", {31'd0, DMEM_REQ_VALID}, 32'd0);

        // FLUSH with READY on a read: DRAIN, response discarded
        issue_load(5'd13, 32'h24, 4'b1111, 1'b0);
        push_bus(1'b0, 32'h24, 4'b1111, 32'd0);
        step();
        idle_in();
        DMEM_REQ_READY = 1'b1; FLUSH = 1'b1;
        step();
        idle_in();
        check("frd_mem_wait", {31'd0, MEM_WAIT}, 32'd1);
        DMEM_RESP_VALID = 1'b1; DMEM_RESP_RDATA = 32'h1;
        step();
        idle_in();
        check("frd_mem_wait_end", {31'd0, MEM_WAIT}, 32'd0);
        check("frd_wb_valid", {31'd0, WB_VALID}, 32'd0);

        // FLUSH in IDLE suppresses an ALU writeback
        IN_VALID = 1'b1; IN_REG_W_EN = 1'b1; IN_REG_W_RD = 5'd8; IN_REG_W_DATA = 32'd9; FLUSH = 1'b1;
        step();
        idle_in();
        check("fidle_wb_valid", {31'd0, WB_VALID}, 32'd0);

`ifdef MEM_MISALIGN_EXC_EN
        issue_load(5'd9, 32'h101, 4'b1111, 1'b0);
        push_wb(1'b0, 5'd0, 32'd0, 1'b1, 4'd4);
        step();
        idle_in();
        check("mis_ld_req_valid", {31'd0, DMEM_REQ_VALID}, 32'd0);
        check("mis_ld_exc_code", {28'd0, WB_EXC_CODE}, 32'd4);
        issue_store(32'h203, 4'b0011, 32'h1234);
        push_wb(1'b0, 5'd0, 32'd0, 1'b1, 4'd6);
        step();
        idle_in();
        check("mis_st_req_valid", {31'd0, DMEM_REQ_VALID}, 32'd0);
        check("mis_st_exc_code", {28'd0, WB_EXC_CODE}, 32'd6);
`else
        push_bus(1'b0, 32'h100, 4'b1110, 32'd0);
        push_wb(1'b1, 5'd9, 32'h0011_2233, 1'b0, 4'd0);
        run_load(5'd9, 32'h101, 4'b1111, 1'b0, 32'h1122_3344, 0);
        issue_store(32'h203, 4'b0011, 32'h1234);
        push_bus(1'b1, 32'h200, 4'b1000, 32'h3400_0000);
        push_wb(1'b0, 5'd0, 32'd0, 1'b0, 4'd0);
        step();
        idle_in();
        DMEM_REQ_READY = 1'b1;
        step();
        DMEM_REQ_READY = 1'b0;
`endif
        step();

        // RST during REQ
        issue_store(32'h10, 4'b0001, 32'h55);
        step();
        idle_in();
        check("rstreq_req_valid_before", {31'd0, DMEM_REQ_VALID}, 32'd1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("rstreq_req_valid", {31'd0, DMEM_REQ_VALID}, 32'd0);
        check("rstreq_mem_wait", {31'd0, MEM_WAIT}, 32'd0);
        check("rstreq_wb_valid", {31'd0, WB_VALID}, 32'd0);

        step();
        step();
        check("wb_queue_empty", wb_q.size(), 32'd0);
        check("bus_queue_empty", bus_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
